// File: rtl/spi_rx_buffer_pkg.sv
// Shared definitions for the SPI receive buffer: FSM encoding and byte width.
package spi_rx_buffer_pkg;

  localparam int SPI_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_rx_buffer_sync_fifo.sv
// First-word-fall-through FIFO. Head is visible on o_rdata without a pop.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ovf_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == CW'(DEPTH));
  assign pop_ok      = i_pop & ~o_empty;
  assign push_ok     = i_push & (~o_full | pop_ok);
  assign o_ovf_pulse = i_push & o_full & ~pop_ok;
  assign o_rdata     = mem_q[rptr_q];
  assign o_count     = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wptr_q] <= i_wdata;
    end
  end

endmodule

// File: rtl/spi_rx_buffer.sv
// SPI receive buffer: detects end of each chip-select window, captures the
// shifted byte into a FWFT FIFO, and reports status, irq and sticky overflow.
//
// state   | meaning
// IDLE    | waiting for chip-select low
// ACTIVE  | chip-select low, counting low time up to MIN_LOW
// CAPTURE | one cycle: push the shift-register byte
module spi_rx_buffer
  import spi_rx_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MIN_LOW = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cs_sync,
  input  logic [SPI_W-1:0]       i_spi_data,
  input  logic                   i_rd,
  input  logic                   i_ovf_clr,
  output logic [SPI_W-1:0]       o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_irq,
  output logic                   o_ovf
);

  localparam int LW = $clog2(MIN_LOW + 1);

  rx_state_e     state_q, state_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic          low_ok;
  logic          push;
  logic          ovf_pulse;
  logic          ovf_q, ovf_d;

  assign low_ok = (low_cnt_q >= LW'(MIN_LOW));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      low_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_cs_sync) begin
          state_d   = ST_ACTIVE;
          low_cnt_d = LW'(1);
        end
      end
      ST_ACTIVE: begin
        if (!i_cs_sync) begin
          if (!low_ok) low_cnt_d = low_cnt_q + LW'(1);
        end else begin
          // Too-short windows are runts and are dropped silently.
          state_d = low_ok ? ST_CAPTURE : ST_IDLE;
        end
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push = 1'b0;
    if (state_q == ST_CAPTURE) push = 1'b1;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (SPI_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_wdata     (i_spi_data),
    .i_pop       (i_rd),
    .o_rdata     (o_rdata),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_count     (o_count),
    .o_ovf_pulse (ovf_pulse)
  );

  // A new overflow beats a clear arriving in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_pulse)      ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign o_ovf = ovf_q;
  assign o_irq = ~o_empty;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Directed bench for spi_rx_buffer with a queue-based reference model.
module tb_spi_rx_buffer;

  localparam int DEPTH   = 4;
  localparam int MIN_LOW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic [7:0] spi_data = 8'h00;
  logic       rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rdata;
  logic       empty, full, irq, ovf;
  logic [2:0] count;

  int nchecks = 0;
  int nerrors = 0;

  spi_rx_buffer #(.DEPTH(DEPTH), .MIN_LOW(MIN_LOW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cs_sync  (cs),
    .i_spi_data (spi_data),
    .i_rd       (rd),
    .i_ovf_clr  (ovf_clr),
    .o_rdata    (rdata),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_irq      (irq),
    .o_ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky flag, and chip-select low-run length.
  byte unsigned mq[$];
  bit  m_ovf = 1'b0;
  int  low_run = 0;
  bit  pend = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_ovf   = 1'b0;
        low_run = 0;
        pend    = 1'b0;
      end else begin
        bit do_pop, do_push, drop;
        do_pop  = rd && (mq.size() > 0);
        do_push = pend;
        drop    = 1'b0;
        if (pend) begin
          pend    = 1'b0;
          low_run = 0;
        end else if (!cs) begin
          low_run++;
        end else begin
          if (low_run >= MIN_LOW) pend = 1'b1;
          low_run = 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          if (mq.size() < DEPTH) mq.push_back(spi_data);
          else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_empty", 32'(empty), 32'(mq.size() == 0));
        chk("m_full",  32'(full),  32'(mq.size() == DEPTH));
        chk("m_irq",   32'(irq),   32'(mq.size() != 0));
        chk("m_ovf",   32'(ovf),   32'(m_ovf));
        if (mq.size() != 0) chk("m_rdata", 32'(rdata), 32'(mq[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Returns just after the push edge.
  task automatic xfer(input logic [7:0] d, input int low);
    spi_data = d;
    cs = 1'b0;
    repeat (low) step();
    cs = 1'b1;
    step();
    step();
  endtask

  task automatic pop1();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full),  0);
    chk("rst_irq",   32'(irq),   0);
    chk("rst_ovf",   32'(ovf),   0);
    chk("rst_rdata", 32'(rdata), 0);
    rst_n = 1'b1;
    step();

    xfer(8'hA5, 8);
    chk("a5_empty", 32'(empty), 0);
    chk("a5_count", 32'(count), 1);
    chk("a5_rdata", 32'(rdata), 32'hA5);
    chk("a5_irq",   32'(irq),   1);
    pop1();
    chk("a5_pop_empty", 32'(empty), 1);
    chk("a5_pop_irq",   32'(irq),   0);

    // Runt: low for one cycle only.
    cs = 1'b0;
    step();
    cs = 1'b1;
    repeat (4) step();
    chk("runt_count", 32'(count), 0);

    for (int i = 1; i <= 5; i++) xfer(8'(i), 2);
    chk("fill_full",  32'(full),  1);
    chk("fill_count", 32'(count), 4);
    chk("fill_ovf",   32'(ovf),   1);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_rdata", 32'(rdata), 32'(i));
      pop1();
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf_held", 32'(ovf), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);

    // Full, with the push edge coinciding with a pop.
    for (int i = 0; i < 4; i++) xfer(8'h10 + 8'(i), 2);
    chk("pp_full", 32'(full), 1);
    spi_data = 8'h14;
    cs = 1'b0;
    step();
    step();
    cs = 1'b1;
    step();
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("pp_count", 32'(count), 4);
    chk("pp_ovf",   32'(ovf),   0);
    for (int i = 1; i <= 4; i++) begin
      chk("pp_order", 32'(rdata), 32'h10 + 32'(i));
      pop1();
    end

    for (int i = 0; i < 10; i++) begin
      xfer(8'h20 + 8'(i), 3);
      chk("wrap_rdata", 32'(rdata), 32'h20 + 32'(i));
      pop1();
    end
    pop1();
    chk("epop_count", 32'(count), 0);
    chk("epop_empty", 32'(empty), 1);
    xfer(8'h77, 2);
    chk("epop_ptr_rdata", 32'(rdata), 32'h77);
    chk("epop_ptr_count", 32'(count), 1);
    pop1();

    // Reset in the middle of a transaction with two bytes stored.
    xfer(8'h31, 2);
    xfer(8'h32, 2);
    chk("pre_rst_count", 32'(count), 2);
    cs = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ovf",   32'(ovf),   0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    cs = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_empty", 32'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/spi_rx_buffer.md
# spi_rx_buffer

Receive-side byte buffer placed directly downstream of the SPI slave shift register, in the system (i_clk) clock domain. It watches the synchronized chip-select, detects the end of each SPI byte transaction, captures the shifted-in byte and pushes it into a small first-word-fall-through FIFO. The 8051 SFR read logic drains the FIFO. The block also provides empty/full/count status, an interrupt request and a sticky overflow flag.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- MIN_LOW, 2, minimum i_cs_sync low time, in i_clk cycles, for a transaction to be accepted; ≥ 1
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_cs_sync  in  1  chip-select already synchronized to i_clk; active-low
- i_spi_data  in  8  parallel content of the SPI shift register; stable while i_cs_sync is high
- i_rd  in  1  pop strobe from the CPU side, one cycle per byte
- i_ovf_clr  in  1  clears o_ovf
- o_rdata  out  8  head-of-FIFO byte (FWFT)
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_count  out  $clog2(DEPTH)+1  number of stored bytes
- o_irq  out  1  level interrupt; equals ~o_empty
- o_ovf  out  1  sticky overflow; a byte was dropped

## Operation
- Reset values:
  - FSM = IDLE; read pointer, write pointer and count = 0.
  - Storage is cleared to 0, so o_rdata = 8'h00.
  - o_empty = 1, o_full = 0, o_count = 0, o_irq = 0, o_ovf = 0.
- FSM states: IDLE, ACTIVE, CAPTURE.
  - IDLE: when i_cs_sync = 0, go to ACTIVE and load the low counter with 1.
  - ACTIVE, i_cs_sync = 0: the low counter increments and saturates at MIN_LOW.
  - ACTIVE, i_cs_sync = 1: go to CAPTURE if low counter ≥ MIN_LOW. Otherwise go to IDLE; this is a runt transaction and is discarded without a push.
  - CAPTURE: lasts one cycle. Issue a push of i_spi_data, then go to IDLE unconditionally. If i_cs_sync is already low again, IDLE picks it up on the next cycle.
- Push rules:
  - Push when not full: write at the write pointer; the write pointer wraps modulo DEPTH; count + 1.
  - Push when full with no pop in the same cycle: the byte is dropped and o_ovf is set. Pointers and count are unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full, so no overflow is flagged.
- Pop rules:
  - Pop with i_rd = 1 when not empty: the read pointer advances with wrap; count − 1.
  - i_rd = 1 when empty: ignored; no state change.
- o_rdata always shows storage[read pointer]. When empty it shows the last popped or stale value, and consumers must qualify it with o_empty.
- o_ovf:
  - Stays set until i_ovf_clr = 1.
  - If an overflow and i_ovf_clr occur in the same cycle, the set wins.
- Reset asserted mid-transaction or mid-capture: everything returns to reset values immediately. The partial byte is lost.

## Timing
- All state changes on the rising edge of i_clk, except reset, which acts asynchronously.
- Capture latency:
  - Edge N: i_cs_sync is first sampled high; FSM moves ACTIVE→CAPTURE.
  - Edge N+1: the push occurs; o_empty and o_count update immediately after edge N+1.
  - o_irq rises together with o_empty falling.
- Pop latency: after the edge that samples i_rd = 1, o_rdata shows the next entry and o_count is decremented.
- Data stability: the upstream CDC adds ≥ 2 cycles between the physical chip-select rising and i_cs_sync rising. i_spi_data therefore has no SCL activity when sampled in CAPTURE.
- Maximum acceptance rate: one byte per MIN_LOW + 2 cycles.

## Structure
- Shared package holds:
  - FSM state encoding constants: IDLE = 2'd0, ACTIVE = 2'd1, CAPTURE = 2'd2.
  - SPI byte width = 8.
- One natural sub-module: sync_fifo, a parameterised FWFT FIFO containing:
  - storage, pointers and count;
  - push, pop, full, empty and overflow-pulse outputs.
- The top level contains the FSM, the low counter and the sticky overflow register.

## Test plan
- Reset, then one transaction with i_cs_sync low for 8 cycles and i_spi_data = 8'hA5 → one cycle after i_cs_sync rises is sampled, o_empty = 0, o_count = 1, o_rdata = 8'hA5, o_irq = 1. Then i_rd = 1 → o_empty = 1, o_irq = 0.
- Runt: i_cs_sync low for 1 cycle with MIN_LOW = 2 → no push; o_count stays 0.
- Fill and overflow:
  - Five transactions with data 01, 02, 03, 04, 05 and no reads → o_full = 1, o_count = 4, o_ovf = 1.
  - Four pops then return 01, 02, 03, 04.
  - After that, i_ovf_clr → o_ovf = 0.
- Full with simultaneous push and pop: the CAPTURE cycle coincides with i_rd = 1 while the FIFO is full → o_count stays 4, o_ovf stays 0, and the new byte appears last in the order.
- Wrap-around and empty pop:
  - 10 push/pop pairs with incrementing data → every byte is read in order.
  - An extra i_rd while empty → o_count stays 0 and the pointers are unchanged.
- Reset mid-operation:
  - Assert i_rst_n = 0 during ACTIVE with 2 bytes stored → o_count = 0, o_empty = 1, o_ovf = 0, o_rdata = 8'h00 immediately.
  - After release, no spurious push occurs.
